// File: rtl/dm_pkg.sv
// Shared types for the debug-module DMI responder: register map, command error
// codes, abstract-command FSM states and register layouts.
package dm;

  typedef enum logic [6:0] {
    ADDR_DATA0      = 7'h04,
    ADDR_DMCONTROL  = 7'h10,
    ADDR_DMSTATUS   = 7'h11,
    ADDR_HARTINFO   = 7'h12,
    ADDR_ABSTRACTCS = 7'h16,
    ADDR_COMMAND    = 7'h17
  } dm_addr_e;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_CHECK,
    CMD_ACCESS,
    CMD_DONE
  } cmd_state_e;

  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [3:0] DM_VERSION   = 4'd2;

  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic [27:0] rsv;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;

  typedef struct packed {
    logic [2:0]  rsv0;
    logic [4:0]  progbufsize;
    logic [10:0] rsv1;
    logic        busy;
    logic        rsv2;
    logic [2:0]  cmderr;
    logic [3:0]  rsv3;
    logic [3:0]  datacount;
  } abstractcs_t;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsv;
    logic [2:0]  aarsize;
    logic        aarpostinc;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } command_t;

  // Only the 32 integer registers are reachable through abstract access.
  function automatic logic regno_is_gpr(input logic [15:0] regno);
    return (regno >= 16'h1000) && (regno <= 16'h101F);
  endfunction

endpackage

// File: rtl/dm_dmi_responder_if.sv
// DMI request/response bundle between the debug transport and the DM.
interface dm_dmi_responder_if;
  import dm::*;

  logic        dmi_start;
  logic        dmi_finish;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_i;
  logic [31:0] dmi_data_o;

  modport master (
    output dmi_start, dmi_op, dmi_address, dmi_data_i,
    input  dmi_finish, dmi_data_o
  );

  modport slave (
    input  dmi_start, dmi_op, dmi_address, dmi_data_i,
    output dmi_finish, dmi_data_o
  );
endinterface

// File: rtl/dm_abstract_cmd.sv
// Abstract-command sequencer: validates a latched command and runs one GPR
// access over the ar_* port.
//   state      | meaning
//   CMD_IDLE   | waiting for an accepted command write
//   CMD_CHECK  | validating command fields and hart state
//   CMD_ACCESS | ar_req held until ar_ack
//   CMD_DONE   | one-cycle completion before returning to idle
module dm_abstract_cmd
  import dm::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  command_t    cmd,
  input  logic        hart_halted,
  input  logic [31:0] data0,
  output logic        busy,
  output logic        err_valid,
  output cmderr_e     err_code,
  output logic        ar_req,
  output logic        ar_write,
  output logic [4:0]  ar_regno,
  output logic [31:0] ar_wdata,
  input  logic        ar_ack,
  output logic        rdata_valid
);

  cmd_state_e state_q, state_d;
  command_t   cmd_q;
  logic       unsupported;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd_q.rsv, cmd_q.aarpostinc, cmd_q.postexec};

  assign unsupported = (cmd_q.cmdtype != 8'd0) || (cmd_q.aarsize != 3'd2) ||
                       (cmd_q.transfer && !regno_is_gpr(cmd_q.regno));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMD_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CMD_IDLE && start) cmd_q <= cmd;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != CMD_IDLE);
    err_valid   = 1'b0;
    err_code    = CMDERR_NONE;
    ar_req      = 1'b0;
    ar_write    = 1'b0;
    ar_regno    = '0;
    ar_wdata    = '0;
    rdata_valid = 1'b0;
    unique case (state_q)
      CMD_IDLE:  if (start) state_d = CMD_CHECK;
      CMD_CHECK: begin
        if (unsupported) begin
          err_valid = 1'b1;
          err_code  = CMDERR_NOTSUP;
          state_d   = CMD_DONE;
        end else if (!hart_halted) begin
          err_valid = 1'b1;
          err_code  = CMDERR_HALTRESUME;
          state_d   = CMD_DONE;
        end else if (!cmd_q.transfer) begin
          state_d = CMD_DONE;
        end else begin
          state_d = CMD_ACCESS;
        end
      end
      CMD_ACCESS: begin
        ar_req   = 1'b1;
        ar_write = cmd_q.write;
        ar_regno = cmd_q.regno[4:0];
        ar_wdata = data0;
        if (ar_ack) begin
          rdata_valid = !cmd_q.write;
          state_d     = CMD_DONE;
        end
      end
      CMD_DONE:  state_d = CMD_IDLE;
      default:   state_d = CMD_IDLE;
    endcase
    // Deactivating the DM drops any in-flight command without side effects.
    if (abort) begin
      state_d     = CMD_IDLE;
      err_valid   = 1'b0;
      rdata_valid = 1'b0;
    end
  end

endmodule

// File: rtl/dm_dmi_responder.sv
// Debug-module DMI responder: two-cycle DMI register access, hart run control
// and the abstract-command register interface.
module dm_dmi_responder
  import dm::*;
#(
  parameter int DATACOUNT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dm_dmi_responder_if.slave   dmi,
  output logic                haltreq,
  output logic                resumereq,
  output logic                ndmreset,
  input  logic                hart_halted,
  input  logic                hart_running,
  output logic                ar_req,
  output logic                ar_write,
  output logic [4:0]          ar_regno,
  output logic [31:0]         ar_wdata,
  input  logic                ar_ack,
  input  logic [31:0]         ar_rdata
);

  logic        pend;
  logic [1:0]  op_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata;

  logic        dmactive, haltreq_q, resumereq_q, ndmreset_q, resumeack;
  logic [31:0] data0;
  cmderr_e     cmderr;

  logic        exec_rd, exec_wr, busy, err_valid, ar_load, abort, busy_viol, cmd_start;
  logic        wr_dmcontrol, wr_data0, wr_abstractcs, wr_command;
  cmderr_e     err_code;
  dmcontrol_t  dmc_rd;
  abstractcs_t acs_rd;

  assign exec_rd       = pend && (op_q == DMI_OP_READ);
  assign exec_wr       = pend && (op_q == DMI_OP_WRITE);
  assign wr_dmcontrol  = exec_wr && (addr_q == ADDR_DMCONTROL);
  assign wr_data0      = exec_wr && (addr_q == ADDR_DATA0);
  assign wr_abstractcs = exec_wr && (addr_q == ADDR_ABSTRACTCS);
  assign wr_command    = exec_wr && (addr_q == ADDR_COMMAND);
  assign abort         = !dmactive || (wr_dmcontrol && !wdata_q[0]);
  assign busy_viol     = busy && (wr_data0 || wr_abstractcs || wr_command ||
                                  (exec_rd && addr_q == ADDR_DATA0));
  assign cmd_start     = wr_command && !abort && !busy && (cmderr == CMDERR_NONE);

  assign haltreq   = haltreq_q;
  assign resumereq = resumereq_q;
  assign ndmreset  = ndmreset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend           <= 1'b0;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      dmi.dmi_finish <= 1'b0;
      dmi.dmi_data_o <= '0;
    end else begin
      pend <= dmi.dmi_start && !pend;
      if (dmi.dmi_start && !pend) begin
        op_q    <= dmi.dmi_op;
        addr_q  <= dmi.dmi_address;
        wdata_q <= dmi.dmi_data_i;
      end
      dmi.dmi_finish <= pend;
      if (pend) dmi.dmi_data_o <= exec_rd ? rdata : '0;
    end
  end

  always_comb begin
    dmc_rd           = '0;
    dmc_rd.haltreq   = haltreq_q;
    dmc_rd.ndmreset  = ndmreset_q;
    dmc_rd.dmactive  = dmactive;
    acs_rd           = '0;
    acs_rd.busy      = busy;
    acs_rd.cmderr    = cmderr;
    acs_rd.datacount = 4'(DATACOUNT);
    rdata            = '0;
    case (addr_q)
      ADDR_DATA0:      rdata = data0;
      ADDR_DMCONTROL:  rdata = dmc_rd;
      ADDR_DMSTATUS:   rdata = {14'd0, {2{resumeack}}, 4'd0, {2{hart_running}},
                                {2{hart_halted}}, 1'b1, 3'd0, DM_VERSION};
      ADDR_ABSTRACTCS: rdata = acs_rd;
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmactive    <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      ndmreset_q  <= 1'b0;
      resumeack   <= 1'b0;
      data0       <= '0;
      cmderr      <= CMDERR_NONE;
    end else begin
      if (wr_dmcontrol) dmactive <= wdata_q[0];
      if (abort) begin
        haltreq_q   <= 1'b0;
        resumereq_q <= 1'b0;
        ndmreset_q  <= 1'b0;
        resumeack   <= 1'b0;
        data0       <= '0;
        cmderr      <= CMDERR_NONE;
      end else begin
        if (resumereq_q && hart_running) begin
          resumereq_q <= 1'b0;
          resumeack   <= 1'b1;
        end
        if (wr_dmcontrol) begin
          haltreq_q  <= wdata_q[31];
          ndmreset_q <= wdata_q[1];
          if (wdata_q[30] && !wdata_q[31]) begin
            resumereq_q <= 1'b1;
            resumeack   <= 1'b0;
          end
        end
        if (wr_data0 && !busy) data0 <= wdata_q;
        else if (ar_load)      data0 <= ar_rdata;
        if (cmderr == CMDERR_NONE) begin
          if (err_valid)      cmderr <= err_code;
          else if (busy_viol) cmderr <= CMDERR_BUSY;
        end else if (wr_abstractcs && !busy) begin
          cmderr <= cmderr_e'(cmderr & ~wdata_q[10:8]);
        end
      end
    end
  end

  dm_abstract_cmd u_abstract_cmd (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .start       (cmd_start),
    .cmd         (command_t'(wdata_q)),
    .hart_halted (hart_halted),
    .data0       (data0),
    .busy        (busy),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .ar_req      (ar_req),
    .ar_write    (ar_write),
    .ar_regno    (ar_regno),
    .ar_wdata    (ar_wdata),
    .ar_ack      (ar_ack),
    .rdata_valid (ar_load)
  );

endmodule

// File: doc/dm_dmi_responder.md
DM_DMI_RESPONDER -- requirements
Module: dm_dmi_responder

Interface
REQ-001 SHALL have parameter DATACOUNT, default 1, number of data registers (only 1 supported).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port dmi_start  input  1  one-cycle pulse requesting a DMI transaction.
REQ-005 SHALL have port dmi_finish  output  1  one-cycle pulse, transaction complete.
REQ-006 SHALL have port dmi_op  input  2  1=read, 2=write, 0/3=nop.
REQ-007 SHALL have port dmi_address  input  7  DM register address.
REQ-008 SHALL have port dmi_data_i  input  32  write data.
REQ-009 SHALL have port dmi_data_o  output  32  read data.
REQ-010 SHALL have ports haltreq, resumereq, ndmreset  output  1 each  hart control levels.
REQ-011 SHALL have ports hart_halted, hart_running  input  1 each  hart status.
REQ-012 SHALL have port ar_req  output  1  abstract register access request, held until ar_ack.
REQ-013 SHALL have ports ar_write (1), ar_regno (5), ar_wdata (32)  output  access write flag, GPR index, write data.
REQ-014 SHALL have ports ar_ack (1), ar_rdata (32)  input  access completion and read data, valid together.

Function
REQ-015 SHALL sample op/address/data on dmi_start; dmi_finish pulses exactly 2 cycles after dmi_start for every register access.
REQ-016 SHALL hold dmi_data_o stable from dmi_finish until the next dmi_start; reads of unimplemented addresses return 0; writes to them are ignored.
REQ-017 SHALL treat op 0/3 as no side effect, finish with dmi_data_o=0.
REQ-018 SHALL ignore dmi_start while a transaction is still pending (before its finish).
REQ-019 SHALL implement 0x04 data0 (RW), 0x10 dmcontrol, 0x11 dmstatus (RO), 0x12 hartinfo (RO, 0), 0x16 abstractcs, 0x17 command (WO, reads 0).
REQ-020 dmcontrol: bit31 haltreq, bit30 resumereq (W1, reads 0), bit1 ndmreset, bit0 dmactive; other bits read 0.
REQ-021 While dmactive=0 all DM state except dmactive SHALL be held at reset values and writes to other fields ignored.
REQ-022 haltreq and ndmreset outputs SHALL equal their dmcontrol bits.
REQ-023 Write with resumereq=1 and haltreq=0 SHALL clear resumeack, raise resumereq output; output drops and resumeack sets in the cycle after hart_running=1.
REQ-024 dmstatus: version[3:0]=2, authenticated bit7=1, anyhalted/allhalted bits8/9=hart_halted, anyrunning/allrunning bits10/11=hart_running, anyresumeack/allresumeack bits16/17=resumeack.
REQ-025 abstractcs: progbufsize[28:24]=0, busy bit12, cmderr[10:8] write-1-to-clear, datacount[3:0]=1.
REQ-026 Command FSM states CMD_IDLE, CMD_CHECK, CMD_ACCESS, CMD_DONE; command write in CMD_IDLE with cmderr=0 enters CMD_CHECK, busy=1.
REQ-027 CMD_CHECK: cmdtype[31:24]!=0, aarsize[22:20]!=2 or (transfer bit17=1 and regno[15:0] outside 0x1000-0x101F) -> cmderr=2; hart_halted=0 -> cmderr=4; error -> CMD_DONE; transfer=0 -> CMD_DONE; else CMD_ACCESS.
REQ-028 CMD_ACCESS: ar_req=1, ar_write=write bit16, ar_regno=regno[4:0], ar_wdata=data0; on ar_ack read loads data0 from ar_rdata, -> CMD_DONE.
REQ-029 CMD_DONE -> CMD_IDLE next cycle, busy=0.
REQ-030 Command write while cmderr!=0 SHALL be ignored.
REQ-031 While busy, writes to command, abstractcs, data0 or reads of data0 SHALL set cmderr=1 if cmderr=0 and have no other effect.
REQ-032 regno 0x1000 (x0) access SHALL complete normally via the port.

Reset
REQ-033 On rst_n low: dmi_finish=0, dmi_data_o=0, haltreq=resumereq=ndmreset=0, ar_req=0, ar_write=0, ar_regno=0, ar_wdata=0, dmactive=0, data0=0, cmderr=0, resumeack=0, command FSM CMD_IDLE, pending transaction dropped.
REQ-034 dmactive write 0 mid-command SHALL abort to CMD_IDLE and deassert ar_req next cycle.

Structure
REQ-035 Package dm SHALL hold the register address enum, cmderr enum, command FSM enum, dmcontrol/abstractcs/command packed structs.
REQ-036 Abstract-command FSM SHALL be sub-module dm_abstract_cmd; DMI decode and registers stay in top.

Verification
REQ-037 Read 0x11 after dmactive=1, hart_halted=1 -> finish at start+2, data 0x0000_0382.
REQ-038 Write 0x10=0x8000_0001 -> haltreq=1; write 0x4000_0001, hart_running rises -> resumereq drops, dmstatus bits16/17=1.
REQ-039 Halted, data0=0xDEAD_BEEF, command 0x0023_1005 -> ar_req, ar_write=1, ar_regno=5, ar_wdata=0xDEAD_BEEF; ack after 3 cycles -> busy=0, cmderr=0.
REQ-040 Halted, command 0x0022_100A, ar_rdata=0x1234_5678 -> data0 reads 0x1234_5678.
REQ-041 Command while ar_ack withheld, then write data0=1 -> cmderr=1, data0 unchanged; write abstractcs 0x700 after done -> cmderr=0.
REQ-042 Hart running, command 0x0022_1001 -> cmderr=4, no ar_req; aarsize=3 -> cmderr=2.
